// File: rtl/n2t_pkg.sv
// Shared types and defaults for the n2t bit-level storage/serial blocks.
// No logic: typedefs and localparams only.
// No flow control.
package n2t_pkg;

    // Default word size for the CPU-side datapath.
    localparam int WORD_WIDTH = 16;

    // Serial transmitter states.
    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } tx_state_t;

endpackage

// File: rtl/n2t_down_counter.sv
// Loadable down counter that saturates at zero and reports a zero flag.
// Latency: load/decrement take effect on the next rising edge; zero is combinational from the count.
// Backpressure: enable=0 holds the count; load has priority over enable.
module n2t_down_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic         enable,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] count,
    output logic         zero
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Next count: reload wins, otherwise decrement and stop at zero.
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (enable && (count_q != '0)) begin
            count_d = count_q - W'(1);
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
    assign zero  = (count_q == '0);

endmodule

// File: rtl/word_bit_tx_n2t.sv
// Serializes a WIDTH-bit word into (out_bit, out_load) pairs for a bit_n2t chain.
// Latency: first bit the cycle after accept, last bit WIDTH stall-free cycles after accept.
// Backpressure: stall freezes shift/count/state; in_ready reopens on the last bit for gapless back-to-back words.
module word_bit_tx_n2t
    import n2t_pkg::*;
#(
    parameter int WIDTH     = WORD_WIDTH,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_word,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             stall,
    output logic             out_bit,
    output logic             out_load,
    output logic             out_last,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH);

    tx_state_t        state_q;
    tx_state_t        state_d;
    logic [WIDTH-1:0] shreg_q;
    logic [WIDTH-1:0] shreg_d;
    logic [CW-1:0]    cnt;
    logic             cnt_zero;
    logic             accept;
    logic             advance;

    assign accept  = in_valid && in_ready;
    assign advance = (state_q == SHIFT) && !stall;

    // Bit counter: loaded with WIDTH-1 on accept, counts down once per emitted bit.
    n2t_down_counter #(
        .W(CW)
    ) u_cnt (
        .clk      (clk),
        .reset    (reset),
        .load     (accept),
        .enable   (advance),
        .load_val (CW'(WIDTH - 1)),
        .count    (cnt),
        .zero     (cnt_zero)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: leave SHIFT only after the last bit goes out with no new word waiting.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) state_d = SHIFT;
            end
            SHIFT: begin
                if (advance && cnt_zero && !accept) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs: all quiet in IDLE; in SHIFT present the output-end bit and gate load with stall.
    always_comb begin
        in_ready = 1'b1;
        out_bit  = 1'b0;
        out_load = 1'b0;
        out_last = 1'b0;
        busy     = 1'b0;
        if (state_q == SHIFT) begin
            busy     = 1'b1;
            out_load = !stall;
            out_bit  = LSB_FIRST ? shreg_q[0] : shreg_q[WIDTH-1];
            out_last = cnt_zero;
            in_ready = cnt_zero && !stall;
        end
    end

    // Shift datapath: reload on accept, else move one bit toward the output end with zero fill.
    always_comb begin
        shreg_d = shreg_q;
        if (accept) begin
            shreg_d = in_word;
        end else if (advance) begin
            if (LSB_FIRST) begin
                shreg_d = {1'b0, shreg_q[WIDTH-1:1]};
            end else begin
                shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
            end
        end
    end

    // Shift register.
    always_ff @(posedge clk) begin
        if (reset) begin
            shreg_q <= '0;
        end else begin
            shreg_q <= shreg_d;
        end
    end

endmodule

// File: doc/word_bit_tx_n2t.md
Name: word_bit_tx_n2t

Overview:
- Transmit side for chains of bit_n2t storage cells.
- Accepts a WIDTH-bit word over a valid/ready handshake and emits it serially, one bit per clock, as an (out_bit, out_load) pair.
- That pair drives the in/load pins of a bit_n2t shift chain or a serial consumer directly.
- Sits between the CPU-side word datapath and bit-level storage or serial links in the 03 sequential-logic layer.

Parameters:
- WIDTH, 16, number of bits per word; legal range 2..32.
- LSB_FIRST, 1, 1 = bit 0 is sent first; 0 = bit WIDTH-1 is sent first.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- in_word  input  WIDTH  word to transmit; sampled on handshake.
- in_valid  input  1  producer has a word on in_word.
- in_ready  output  1  block can accept a word this cycle.
- stall  input  1  consumer back-pressure; freezes transmission.
- out_bit  output  1  current serial bit.
- out_load  output  1  out_bit is valid this cycle; drives the bit_n2t load pin.
- out_last  output  1  current bit is the final bit of the word.
- busy  output  1  a word is in flight (state SHIFT).

Behaviour:
- Interface: one clock; reset is synchronous and active-high (ports clk, reset).
- Reset values:
  - State IDLE; shift register = 0; bit counter = 0.
  - out_bit=0, out_load=0, out_last=0, busy=0.
  - in_ready=1 from the first cycle after reset is released.
- Handshake:
  - A word is accepted on a rising edge where in_valid && in_ready.
  - in_word is captured into the shift register and the counter is set to WIDTH-1.
  - in_ready is combinational: 1 in IDLE; 1 in SHIFT only when out_last && !stall; 0 otherwise.
- State IDLE:
  - out_load=0, out_bit=0.
  - On accept, go to SHIFT.
- State SHIFT:
  - out_load = !stall.
  - out_bit = shreg[0] if LSB_FIRST, else shreg[WIDTH-1].
  - out_last = (counter == 0).
  - Each cycle with !stall: shift by one toward the output end, zero-fill the vacated end, decrement the counter.
  - On a cycle with !stall && out_last:
    - If a word is accepted in the same cycle, reload and stay in SHIFT (back-to-back, no bubble).
    - Otherwise go to IDLE.
- Stall:
  - While stall=1, shift register, counter and state are held; out_bit keeps its value; out_load=0.
  - stall has no effect in IDLE.
- Latency:
  - Word accepted at edge N: first out_load=1 in cycle N+1 (if stall=0).
  - Final bit in cycle N+WIDTH, with WIDTH stall-free cycles.
- Throughput: one word per WIDTH cycles with continuous in_valid and no stall.
- Reset mid-word: the word is aborted and never completed, the state returns to IDLE, and all outputs take their reset values on the next cycle.
- reset has priority over handshake and stall in the same cycle.
- in_valid while in_ready=0 is ignored; the producer must hold in_word until accepted.
- Counter width: $clog2(WIDTH); there is no wrap beyond 0. It only reloads on accept.

Decomposition:
- Package n2t_pkg holds:
  - WORD_WIDTH = 16 as the default word size.
  - typedef enum logic {IDLE, SHIFT} tx_state_t.
- One natural sub-module: n2t_down_counter (load, enable, reset, zero flag), reused later by the PC/timer blocks.
- The shift register and FSM stay in the top module.

Test Plan:
- Reset then idle: hold reset 2 cycles, release -> in_ready=1, out_load=0, busy=0, out_bit=0.
- Single word, LSB_FIRST=1:
  - Stimulus: in_word=16'hA5C3, in_valid for 1 cycle.
  - Required: 16 consecutive out_load=1 cycles carrying bits 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1, with out_last only on the 16th, then IDLE.
  - Feeding out_bit/out_load into a 16-deep bit_n2t chain reproduces 16'hA5C3.
- MSB first (LSB_FIRST=0), in_word=16'h8001 -> first bit 1, bits 2..15 zero, 16th bit 1.
- Back-to-back:
  - Stimulus: 16'hFFFF then 16'h0000 with in_valid held.
  - Required: in_ready=1 exactly on the out_last cycle, the second word starts the next cycle with no gap, and 32 contiguous out_load cycles.
- Stall:
  - Stimulus: assert stall for 3 cycles after bit 5 of 16'h1234.
  - Required: out_load=0 and out_bit held for those 3 cycles, the sequence resumes at bit 6, and the total is 19 cycles.
- Reset mid-word:
  - Stimulus: assert reset at bit 8 of 16'hBEEF.
  - Required: the next cycle is IDLE with all outputs 0; a new word 16'h0003 then transmits correctly from bit 0.
